// File: rtl/parser_lit_fifo.sv
// Synchronous FIFO with registered read data, programmable full/empty thresholds.
// Optional sticky overflow/underflow flags enabled by macro PARSER_LIT_FIFO_ERR_FLAGS_EN.
module parser_lit_fifo #(
    parameter int unsigned WIDTH             = 85,
    parameter int unsigned DEPTH             = 8,
    parameter int unsigned PROG_FULL_THRESH  = 3,
    parameter int unsigned PROG_EMPTY_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         din,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     prog_full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     empty,
    output logic                     prog_empty,
    output logic [$clog2(DEPTH):0]   data_count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_PFULL = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] LP_PEMPTY = CW'(PROG_EMPTY_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;

    logic w_rd_acc;
    logic w_wr_acc;

    // Status flags depend only on the registered occupancy.
    assign full       = (r_count == LP_DEPTH);
    assign empty      = (r_count == '0);
    assign prog_full  = (r_count >= LP_PFULL);
    assign prog_empty = (r_count <= LP_PEMPTY);

    assign w_rd_acc = rd_en && !empty;
    assign w_wr_acc = wr_en && (!full || w_rd_acc);

    assign dout       = r_dout;
    assign valid      = r_valid;
    assign data_count = r_count;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PARSER_LIT_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_parser_lit_fifo.sv
// Self-checking bench for parser_lit_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
`timescale 1ns/100ps
module tb_parser_lit_fifo;

    localparam int unsigned WIDTH = 85;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PFT   = 3;
    localparam int unsigned PET   = 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             full;
    logic             prog_full;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             empty;
    logic             prog_empty;
    logic [3:0]       data_count;
    logic             overflow;
    logic             underflow;

    parser_lit_fifo #(
        .WIDTH             (WIDTH),
        .DEPTH             (DEPTH),
        .PROG_FULL_THRESH  (PFT),
        .PROG_EMPTY_THRESH (PET)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .wr_en      (wr_en),
        .full       (full),
        .prog_full  (prog_full),
        .rd_en      (rd_en),
        .dout       (dout),
        .valid      (valid),
        .empty      (empty),
        .prog_empty (prog_empty),
        .data_count (data_count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout;
    bit               exp_valid;
    bit               exp_ovf;
    bit               exp_udf;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int occ;
        occ = q.size();
        check({ctx, ".dout"},       128'(dout),       128'(exp_dout));
        check({ctx, ".valid"},      128'(valid),      128'(exp_valid));
        check({ctx, ".data_count"}, 128'(data_count), 128'(occ));
        check({ctx, ".full"},       128'(full),       128'(occ == DEPTH));
        check({ctx, ".empty"},      128'(empty),      128'(occ == 0));
        check({ctx, ".prog_full"},  128'(prog_full),  128'(occ >= PFT));
        check({ctx, ".prog_empty"}, 128'(prog_empty), 128'(occ <= PET));
        check({ctx, ".overflow"},   128'(overflow),   128'(exp_ovf));
        check({ctx, ".underflow"},  128'(underflow),  128'(exp_udf));
    endtask

    // One clock of stimulus; model is updated from the acceptance rules, then outputs checked.
    task automatic cycle(input string ctx, input bit wr, input bit rd, input logic [WIDTH-1:0] d);
        bit rd_acc;
        bit wr_acc;
        wr_en  = wr;
        rd_en  = rd;
        din    = d;
        rd_acc = rd && (q.size() != 0);
        wr_acc = wr && ((q.size() < DEPTH) || rd_acc);
`ifdef PARSER_LIT_FIFO_ERR_FLAGS_EN
        if (wr && !wr_acc) exp_ovf = 1'b1;
        if (rd && !rd_acc) exp_udf = 1'b1;
`endif
        @(posedge clk);
        #1;
        if (rd_acc) exp_dout = q.pop_front();
        if (wr_acc) q.push_back(d);
        exp_valid = rd_acc;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all(ctx);
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        return WIDTH'({$urandom, $urandom, $urandom});
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        rst_n    = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        #1;
        rst_n = 1'b1;

        // Fill to full with 1..8, then drain in order
        for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 1'b0, WIDTH'(i));
        for (int i = 1; i <= 8; i++) cycle("drain", 1'b0, 1'b1, '0);

        // Simultaneous write and read on empty: only the write is taken
        cycle("empty_wr_rd", 1'b1, 1'b1, WIDTH'(8'hAA));
        cycle("empty_wr_rd_read", 1'b0, 1'b1, '0);

        // Interleaved traffic keeping occupancy between 2 and 6
        cycle("ilv_pre", 1'b1, 1'b0, rnd());
        cycle("ilv_pre", 1'b1, 1'b0, rnd());
        for (int i = 0; i < 40; i++) begin
            int occ;
            bit w;
            occ = q.size();
            if (occ <= 2)      w = 1'b1;
            else if (occ >= 6) w = 1'b0;
            else               w = bit'($urandom_range(1, 0));
            cycle("ilv", w, !w, rnd());
        end
        while (q.size() != 0) cycle("ilv_drain", 1'b0, 1'b1, '0);

        // Full FIFO: simultaneous write/read, then write alone is ignored
        for (int i = 0; i < 8; i++) cycle("full_fill", 1'b1, 1'b0, rnd());
        cycle("full_wr_rd", 1'b1, 1'b1, WIDTH'(8'h55));
        cycle("full_wr_only", 1'b1, 1'b0, rnd());
        for (int i = 0; i < 8; i++) cycle("full_drain", 1'b0, 1'b1, '0);

        // Reads on empty are ignored and leave dout alone
        for (int i = 0; i < 3; i++) cycle("empty_rd", 1'b0, 1'b1, '0);

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 1'b0, rnd());
        wr_en = 1'b1;
        din   = rnd();
        #2;
        rst_n = 1'b0;
        #0.5;
        model_reset();
        check_all("async_rst");
        #0.5;
        rst_n = 1'b1;
        wr_en = 1'b0;
        cycle("post_rst_wr", 1'b1, 1'b0, rnd());
        cycle("post_rst_rd", 1'b0, 1'b1, '0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle("rand", bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)), rnd());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parser_lit_fifo.md
PARSER_LIT_FIFO -- requirements
Module: parser_lit_fifo

Interface
REQ-001 SHALL take parameter WIDTH, default 85, data word width in bits (1..512).
REQ-002 SHALL take parameter DEPTH, default 8, number of entries; power of two, 2..256.
REQ-003 SHALL take parameter PROG_FULL_THRESH, default 3, occupancy at or above which prog_full asserts (1..DEPTH).
REQ-004 SHALL take parameter PROG_EMPTY_THRESH, default 1, occupancy at or below which prog_empty asserts (0..DEPTH-1).
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port din  in  WIDTH  write data.
REQ-008 SHALL have port wr_en  in  1  write request.
REQ-009 SHALL have port full  out  1  occupancy == DEPTH.
REQ-010 SHALL have port prog_full  out  1  occupancy >= PROG_FULL_THRESH.
REQ-011 SHALL have port rd_en  in  1  read request.
REQ-012 SHALL have port dout  out  WIDTH  read data, registered.
REQ-013 SHALL have port valid  out  1  dout holds a word popped on the previous cycle.
REQ-014 SHALL have port empty  out  1  occupancy == 0.
REQ-015 SHALL have port prog_empty  out  1  occupancy <= PROG_EMPTY_THRESH.
REQ-016 SHALL have port data_count  out  clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have ports overflow, underflow  out  1 each  sticky error flags (see REQ-032).

Function
REQ-018 SHALL store words in a DEPTH-entry array with read/write pointers of clog2(DEPTH) bits wrapping DEPTH-1 -> 0 naturally.
REQ-019 SHALL accept a write iff wr_en && (!full || rd_en accepted same cycle); accepted write stores din at write pointer, pointer +1.
REQ-020 SHALL accept a read iff rd_en && !empty; accepted read loads dout with entry at read pointer, pointer +1.
REQ-021 SHALL give read latency of one cycle: valid high in cycle N+1 exactly when read accepted in cycle N, else low.
REQ-022 SHALL hold dout unchanged when no read is accepted.
REQ-023 SHALL update data_count: +1 write only, -1 read only, unchanged for both or neither.
REQ-024 SHALL, on empty with wr_en && rd_en, accept the write only; read ignored, valid low next cycle.
REQ-025 SHALL, on full with wr_en && rd_en, accept both; occupancy stays DEPTH.
REQ-026 SHALL ignore wr_en when full without accepted read; array, pointer, count unchanged.
REQ-027 SHALL ignore rd_en when empty; dout unchanged.
REQ-028 SHALL derive full, empty, prog_full, prog_empty combinationally from registered data_count only (no din/wr_en/rd_en path).
REQ-029 SHALL never return a word written in the same cycle as its read (no bypass).

Reset
REQ-030 SHALL on rst_n low asynchronously clear pointers, data_count, dout (all zeros), valid, overflow, underflow; empty=1, prog_empty=1, full=0, prog_full=0.
REQ-031 SHALL discard all stored words on reset mid-operation; array contents need not be cleared; first post-reset read returns first post-reset write.

Configuration
REQ-032 SHALL, with macro PARSER_LIT_FIFO_ERR_FLAGS_EN defined, set overflow sticky on wr_en ignored per REQ-026 and underflow sticky on rd_en ignored per REQ-027/024, both cleared only by reset.
REQ-033 SHALL, without PARSER_LIT_FIFO_ERR_FLAGS_EN, drive overflow and underflow constant 0 and instantiate no flag logic.

Verification (WIDTH=85, DEPTH=8, PROG_FULL_THRESH=3, PROG_EMPTY_THRESH=1)
REQ-034 SHALL cover: write 0x1..0x8 back-to-back -> full=1 after 8th, data_count=8, prog_full=1 from 3rd write; then read 8 -> dout 0x1..0x8 in order, valid each cycle one after rd_en, empty=1 at end.
REQ-035 SHALL cover: 20 writes/reads interleaved keeping occupancy 2..6 -> pointer wrap twice, output sequence matches input, no loss.
REQ-036 SHALL cover: empty FIFO, wr_en=rd_en=1 with din=0xAA -> valid=0 next cycle, data_count=1; next read returns 0xAA.
REQ-037 SHALL cover: full FIFO, wr_en=rd_en=1 din=0x55 -> oldest word out, data_count stays 8, 0x55 emerges 8th read later; wr_en alone on full -> ignored, overflow=1 only with macro.
REQ-038 SHALL cover: rst_n low for 1 ns mid-burst with 5 entries, asynchronous to clk -> outputs at reset values immediately; next write/read pair returns the new word.
REQ-039 SHALL cover: rd_en on empty for 3 cycles -> dout unchanged, valid=0, underflow=1 with macro and 0 without.
